// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave modport.
interface multicycle_ctrl_if;
    logic [5:0] instr_op_i;
    logic [5:0] funct_i;
    logic       mem_ready_i;
    logic       mem_req_o;
    logic       mem_we_o;
    logic       iord_o;
    logic       ir_write_o;
    logic       pc_write_o;
    logic [1:0] pc_src_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       branch_o;
    logic [1:0] branch_type_o;
    logic       reg_write_o;
    logic [1:0] reg_dst_o;
    logic [1:0] mem_to_reg_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;

    modport master (
        input  instr_op_i, funct_i, mem_ready_i,
        output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, branch_o, branch_type_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, instr_done_o, illegal_o, state_o
    );

    modport slave (
        output instr_op_i, funct_i, mem_ready_i,
        input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, branch_o, branch_type_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multi-cycle MIPS datapath: one micro-step per cycle,
// memory wait states on FETCH/MEM_RD/MEM_WR, and an illegal-opcode pulse in DECODE.
module multicycle_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLT   = 6'b000110;
    localparam logic [5:0] OP_BLE   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       jr_q, jr_d;
    logic       dec_legal;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       branch;
    logic [1:0] branch_type;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
    logic       illegal;

    // State register; the opcode is latched only on leaving DECODE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            op_q    <= '0;
            jr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            jr_q    <= jr_d;
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        case (bus.instr_op_i)
            OP_RTYPE, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLT, OP_BLE,
            OP_ADDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW: dec_legal = 1'b1;
            default:      dec_legal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        jr_d    = jr_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                op_d = bus.instr_op_i;
                jr_d = (bus.instr_op_i == OP_RTYPE) && (bus.funct_i == FN_JR);
                case (bus.instr_op_i)
                    OP_RTYPE:                        state_d = (bus.funct_i == FN_JR) ? JUMP : EXEC_R;
                    OP_LW, OP_SW:                    state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLT, OP_BLE:  state_d = BRANCH;
                    OP_ADDI, OP_LUI, OP_ORI:         state_d = EXEC_I;
                    OP_J, OP_JAL:                    state_d = JUMP;
                    default:                         state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (bus.mem_ready_i) state_d = MEM_WB;
            end
            MEM_WB:   state_d = FETCH;
            MEM_WR: begin
                if (bus.mem_ready_i) state_d = FETCH;
            end
            EXEC_R:   state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            EXEC_I:   state_d = I_WB;
            I_WB:     state_d = FETCH;
            JUMP:     state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Output logic; everything is forced low during the reset cycle so an
    // outstanding request or write strobe never survives a reset.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;
        branch      = 1'b0;
        branch_type = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (!rst_i) begin
            case (state_q)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready_i;
                    pc_write  = bus.mem_ready_i;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal    = !dec_legal;
                    instr_done = !dec_legal;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    instr_done = 1'b1;
                end
                MEM_WR: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    iord       = 1'b1;
                    instr_done = bus.mem_ready_i;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b010;
                end
                R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 3'b001;
                    branch     = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = 2'b01;
                    instr_done = 1'b1;
                    case (op_q)
                        OP_BNE:  branch_type = 2'b11;
                        OP_BLT:  branch_type = 2'b10;
                        OP_BLE:  branch_type = 2'b01;
                        default: branch_type = 2'b00;
                    endcase
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (op_q)
                        OP_LUI:  alu_op = 3'b011;
                        OP_ORI:  alu_op = 3'b100;
                        default: alu_op = 3'b000;
                    endcase
                end
                I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = jr_q ? 2'b11 : 2'b10;
                    instr_done = 1'b1;
                    if (op_q == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req_o     = mem_req;
    assign bus.mem_we_o      = mem_we;
    assign bus.iord_o        = iord;
    assign bus.ir_write_o    = ir_write;
    assign bus.pc_write_o    = pc_write;
    assign bus.pc_src_o      = pc_src;
    assign bus.alu_src_a_o   = alu_src_a;
    assign bus.alu_src_b_o   = alu_src_b;
    assign bus.alu_op_o      = alu_op;
    assign bus.branch_o      = branch;
    assign bus.branch_type_o = branch_type;
    assign bus.reg_write_o   = reg_write;
    assign bus.reg_dst_o     = reg_dst;
    assign bus.mem_to_reg_o  = mem_to_reg;
    assign bus.instr_done_o  = instr_done;
    assign bus.illegal_o     = illegal;
    assign bus.state_o       = rst_i ? 4'd0 : state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the shared multi-cycle MIPS datapath: one ALU, one unified instruction/data memory port, one register file. It reads the opcode/funct from the datapath's instruction register and drives every mux select, write strobe and memory request, one micro-step per cycle. It handles memory wait states and flags undefined opcodes.

## Interface
- No parameters.
- clk_i  in  1  system clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_op_i  in  6  opcode from instruction register
- funct_i  in  6  funct field from instruction register
- mem_ready_i  in  1  memory completes current request this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write request (valid with mem_req_o)
- iord_o  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  load PC (conditional for branches, gated in datapath)
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target, 11 = rs (jr)
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op_o  out  3  000 add, 001 sub/compare, 010 R-type by funct, 011 lui, 100 ori
- branch_o  out  1  branch evaluation cycle
- branch_type_o  out  2  00 beq, 01 ble, 10 blt, 11 bne
- reg_write_o  out  1  register file write
- reg_dst_o  out  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg_o  out  2  00 = ALUOut, 01 = MDR, 11 = PC (already PC+4)
- instr_done_o  out  1  one-cycle pulse on final cycle of each instruction
- illegal_o  out  1  one-cycle pulse: undefined opcode/funct in DECODE
- state_o  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, EXEC_I 9, I_WB 10, JUMP 11. Codes 12–15 are unreachable; if entered, next state is FETCH.
- FETCH: mem_req=1, iord=0, src_a=0, src_b=01, alu_op=000. Hold while mem_ready_i=0. On ready: ir_write=1, pc_write=1, pc_src=00, go DECODE.
- DECODE: src_a=0, src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 000000 jr (funct 001000) -> JUMP; other R-type -> EXEC_R
  - 100011 lw / 101011 sw -> MEM_ADDR
  - 000100, 000101, 000110, 000111 -> BRANCH
  - 001000, 001111, 001101 -> EXEC_I
  - 000010 j / 000011 jal -> JUMP
  - any other opcode: illegal_o=1, instr_done_o=1, go FETCH
- MEM_ADDR: src_a=1, src_b=10, alu_op=000. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1; wait for ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
- MEM_WR: mem_req=1, mem_we=1, iord=1; wait for ready, then FETCH.
- EXEC_R: src_a=1, src_b=00, alu_op=010. R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
- BRANCH: src_a=1, src_b=00, alu_op=001, branch=1, pc_write=1, pc_src=01, branch_type: beq 00, ble 01 (000111), blt 10 (000110), bne 11 (000101).
- EXEC_I: src_a=1, src_b=10, alu_op=000 (addi), 011 (lui), 100 (ori). I_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
- JUMP: pc_write=1, pc_src=10 (j/jal) or 11 (jr). jal additionally sets reg_write=1, reg_dst=10, mem_to_reg=11.
- MEM_WB, MEM_WR (on ready), R_WB, BRANCH, I_WB and JUMP go to FETCH and assert instr_done_o.
- Outputs not listed for a state are 0.

## Timing
- Reset: while rst_i=1, every output is 0 and state_o=0. The first cycle after reset is FETCH.
- Reset mid-operation (including an outstanding memory wait) abandons the instruction. mem_req_o drops in the reset cycle. No writes occur.
- Outputs are a function of registered state, except the FETCH ir_write/pc_write/next-state and the MEM_RD/MEM_WR exits, which depend on the same-cycle mem_ready_i.
- mem_req_o stays high and the address select stays stable until mem_ready_i is sampled high. A zero-wait memory means ready is asserted in the first request cycle.
- Latency in cycles, with zero-wait memory: lw 5; sw, R-type, I-type 4; branch, j, jal, jr 3; illegal 2. Each memory wait cycle adds 1.
- The opcode is sampled only in DECODE. instr_op_i changes in other states are ignored.

## Test plan
- Reset in FETCH, then release with ready=1: one FETCH cycle with ir_write=pc_write=1, then DECODE.
- lw (100011) with mem_ready_i low 2 cycles in MEM_RD: states 0,1,2,3,3,3,4. MEM_WB shows reg_write=1, mem_to_reg=01, instr_done=1. Total 7 cycles.
- blt (000110): BRANCH cycle has branch=1, branch_type=10, alu_op=001, pc_src=01, pc_write=1. Back to FETCH after 3 cycles.
- jal (000011) then jr (000000 / funct 001000): JUMP shows pc_src=10, reg_dst=10, mem_to_reg=11, reg_write=1; then pc_src=11 with reg_write=0.
- Opcode 111111: DECODE pulses illegal_o=1 and instr_done_o=1. Next state FETCH, no write strobes asserted.
- rst_i asserted during MEM_WR wait: mem_req/mem_we drop in the reset cycle, and the FSM is in FETCH on the next cycle.
